// File: rtl/apb_slave_regbank_if.sv
// APB bus bundle between the upstream master stage and the register-bank completer.
interface apb_slave_regbank_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [3:0]            pstrb;
    logic [2:0]            pprot;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_regbank.sv
// APB completer: NUM_REGS RW control registers plus a read-only ID word,
// fixed wait-state insertion, byte-lane writes and PSLVERR on illegal accesses.
module apb_slave_regbank #(
    parameter int unsigned          ADDR_WIDTH  = 32,
    parameter int unsigned          DATA_WIDTH  = 32,
    parameter int unsigned          NUM_REGS    = 8,
    parameter int unsigned          WAIT_STATES = 1,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA9B0_0001
) (
    input  logic                           pclk,
    input  logic                           presetn,
    apb_slave_regbank_if.slave             bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr_stb
);
    localparam int unsigned OFF_W = ADDR_WIDTH - 2;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned NB    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [OFF_W-1:0]      off_q, off_d;
    logic                  err_q, err_d;
    logic                  wr_q, wr_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   stb_q, stb_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;

    logic [OFF_W-1:0]      cur_off;
    logic                  cur_err;
    logic                  load_rsp;
    logic [OFF_W-1:0]      rsp_off;
    logic                  rsp_err;
    logic                  rsp_wr;
    logic                  unused_pprot;

    assign unused_pprot = ^bus.pprot;

    // Address decode of the current bus cycle; only meaningful during setup.
    assign cur_off = bus.paddr[ADDR_WIDTH-1:2];
    assign cur_err = (bus.paddr[1:0] != 2'b00)
                   || (cur_off > OFF_W'(NUM_REGS))
                   || ((cur_off == OFF_W'(NUM_REGS)) && bus.pwrite);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        off_d     = off_q;
        err_d     = err_q;
        wr_d      = wr_q;
        regs_d    = regs_q;
        stb_d     = '0;
        prdata_d  = '0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        load_rsp  = 1'b0;
        rsp_off   = off_q;
        rsp_err   = err_q;
        rsp_wr    = wr_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.psel && !bus.penable) begin
                    off_d = cur_off;
                    err_d = cur_err;
                    wr_d  = bus.pwrite;
                    cnt_d = CNT_W'(WAIT_STATES);
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                    end else begin
                        // No wait states: response is built from the live decode.
                        state_d  = ST_DONE;
                        load_rsp = 1'b1;
                        rsp_off  = cur_off;
                        rsp_err  = cur_err;
                        rsp_wr   = bus.pwrite;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (!bus.psel) begin
                    state_d = ST_IDLE;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d  = ST_DONE;
                    load_rsp = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (bus.psel && bus.penable && bus.pwrite && !err_q) begin
                    for (int n = 0; n < int'(NUM_REGS); n++) begin
                        if (off_q == OFF_W'(n)) begin
                            stb_d[n] = 1'b1;
                            for (int b = 0; b < int'(NB); b++) begin
                                if (bus.pstrb[b]) begin
                                    regs_d[n][8*b +: 8] = bus.pwdata[8*b +: 8];
                                end
                            end
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Response registers are loaded on entry to DONE.
        if (load_rsp) begin
            pready_d  = 1'b1;
            pslverr_d = rsp_err;
            if (!rsp_err && !rsp_wr) begin
                for (int n = 0; n < int'(NUM_REGS); n++) begin
                    if (rsp_off == OFF_W'(n)) begin
                        prdata_d = regs_q[n];
                    end
                end
                if (rsp_off == OFF_W'(NUM_REGS)) begin
                    prdata_d = ID_VALUE;
                end
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            off_q     <= '0;
            err_q     <= 1'b0;
            wr_q      <= 1'b0;
            regs_q    <= '{default: '0};
            stb_q     <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            off_q     <= off_d;
            err_q     <= err_d;
            wr_q      <= wr_d;
            regs_q    <= regs_d;
            stb_q     <= stb_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    for (genvar n = 0; n < int'(NUM_REGS); n++) begin : g_pack
        assign reg_q[n*DATA_WIDTH +: DATA_WIDTH] = regs_q[n];
    end

    assign reg_wr_stb  = stb_q;
    assign bus.prdata  = prdata_q;
    assign bus.pready  = pready_q;
    assign bus.pslverr = pslverr_q;
endmodule

// File: tb/tb_apb_slave_regbank.sv
// Bench for apb_slave_regbank: one instance with 1 wait state and one with 3,
// directed vector table, hand-written corner sequences and a randomized run against a model.
module tb_apb_slave_regbank;
    localparam logic [31:0] ID = 32'hA9B0_0001;

    logic pclk = 1'b0;
    logic presetn;
    always #5 pclk = ~pclk;

    apb_slave_regbank_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    apb_slave_regbank_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

    logic [31:0]  paddr_v   [2];
    logic         psel_v    [2];
    logic         penable_v [2];
    logic         pwrite_v  [2];
    logic [31:0]  pwdata_v  [2];
    logic [3:0]   pstrb_v   [2];
    logic [31:0]  prdata_v  [2];
    logic         pready_v  [2];
    logic         pslverr_v [2];
    logic [255:0] regq_v    [2];
    logic [7:0]   stb_v     [2];
    logic [255:0] rq0, rq1;
    logic [7:0]   st0, st1;

    assign bus0.paddr = paddr_v[0];   assign bus1.paddr = paddr_v[1];
    assign bus0.psel = psel_v[0];     assign bus1.psel = psel_v[1];
    assign bus0.penable = penable_v[0]; assign bus1.penable = penable_v[1];
    assign bus0.pwrite = pwrite_v[0]; assign bus1.pwrite = pwrite_v[1];
    assign bus0.pwdata = pwdata_v[0]; assign bus1.pwdata = pwdata_v[1];
    assign bus0.pstrb = pstrb_v[0];   assign bus1.pstrb = pstrb_v[1];
    assign bus0.pprot = 3'b010;       assign bus1.pprot = 3'b101;
    assign prdata_v[0] = bus0.prdata; assign prdata_v[1] = bus1.prdata;
    assign pready_v[0] = bus0.pready; assign pready_v[1] = bus1.pready;
    assign pslverr_v[0] = bus0.pslverr; assign pslverr_v[1] = bus1.pslverr;
    assign regq_v[0] = rq0;           assign regq_v[1] = rq1;
    assign stb_v[0] = st0;            assign stb_v[1] = st1;

    apb_slave_regbank #(.NUM_REGS(8), .WAIT_STATES(1)) dut0 (
        .pclk(pclk), .presetn(presetn), .bus(bus0), .reg_q(rq0), .reg_wr_stb(st0));
    apb_slave_regbank #(.NUM_REGS(8), .WAIT_STATES(3)) dut1 (
        .pclk(pclk), .presetn(presetn), .bus(bus1), .reg_q(rq1), .reg_wr_stb(st1));

    int checks = 0;
    int failures = 0;
    logic [31:0] mdl [2][8];

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [31:0] exp_reg2;
    } vec_t;
    vec_t vecs [$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int ws(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [255:0] model_regs(input int d);
        logic [255:0] r;
        for (int n = 0; n < 8; n++) r[n*32 +: 32] = mdl[d][n];
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int n = 0; n < 8; n++) mdl[d][n] = 32'h0;
    endtask

    // Reference behaviour of one completed transfer, from the address map rules.
    task automatic model(input int d, input logic [31:0] addr, input logic wr,
                         input logic [31:0] wd, input logic [3:0] strb,
                         output logic e_err, output logic [31:0] e_rd, output logic [7:0] e_stb);
        int unsigned off;
        logic [31:0] m;
        off   = addr / 4;
        e_err = (addr % 4 != 0) || (off > 8) || (off == 8 && wr);
        e_rd  = 32'h0;
        e_stb = 8'h0;
        if (!e_err) begin
            if (wr) begin
                m = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
                mdl[d][off] = (mdl[d][off] & ~m) | (wd & m);
                e_stb = 8'(1 << off);
            end else begin
                e_rd = (off == 8) ? ID : mdl[d][off];
            end
        end
    endtask

    // Full transfer; called at a negedge, returns at the negedge of the following IDLE cycle.
    task automatic xfer(input int d, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        output logic [31:0] rdata, output logic err);
        logic e_err;
        logic [31:0] e_rd;
        logic [7:0] e_stb;
        int cyc;
        model(d, addr, wr, wdata, strb, e_err, e_rd, e_stb);
        psel_v[1-d] = 1'b0; penable_v[1-d] = 1'b0;
        paddr_v[d] = addr; pwrite_v[d] = wr; pwdata_v[d] = wdata; pstrb_v[d] = strb;
        psel_v[d] = 1'b1; penable_v[d] = 1'b0;
        @(negedge pclk);
        penable_v[d] = 1'b1;
        cyc = 1;
        while (!pready_v[d] && cyc < 40) begin
            @(negedge pclk);
            cyc++;
        end
        chk("access_cycles", 256'(cyc), 256'(ws(d) + 1));
        rdata = prdata_v[d];
        err   = pslverr_v[d];
        chk("pslverr", 256'(err), 256'(e_err));
        if (!wr || e_err) chk("prdata", 256'(rdata), 256'(e_rd));
        @(negedge pclk);
        chk("pready_after_done", 256'(pready_v[d]), 256'(0));
        chk("reg_wr_stb", 256'(stb_v[d]), 256'(e_stb));
        chk("reg_q", regq_v[d], model_regs(d));
    endtask

    task automatic idle(input int d);
        psel_v[d] = 1'b0; penable_v[d] = 1'b0;
        @(negedge pclk);
    endtask

    // Write whose psel drops after drop_after access cycles; must leave no trace.
    task automatic abort_write(input int d, input logic [31:0] addr, input int drop_after);
        paddr_v[d] = addr; pwrite_v[d] = 1'b1; pwdata_v[d] = 32'h5A5A_A5A5; pstrb_v[d] = 4'hF;
        psel_v[d] = 1'b1; penable_v[d] = 1'b0;
        @(negedge pclk);
        penable_v[d] = 1'b1;
        repeat (drop_after - 1) @(negedge pclk);
        psel_v[d] = 1'b0; penable_v[d] = 1'b0;
        repeat (4) begin
            @(negedge pclk);
            chk("abort_pready", 256'(pready_v[d]), 256'(0));
            chk("abort_stb", 256'(stb_v[d]), 256'(0));
        end
        chk("abort_reg_q", regq_v[d], model_regs(d));
    endtask

    initial begin
        logic [31:0] rd;
        logic er;
        int d, last;
        logic [31:0] a;

        for (int i = 0; i < 2; i++) begin
            paddr_v[i] = '0; psel_v[i] = 0; penable_v[i] = 0; pwrite_v[i] = 0;
            pwdata_v[i] = '0; pstrb_v[i] = '0;
        end
        model_reset();
        presetn = 1'b1;
        #2 presetn = 1'b0;
        repeat (2) @(negedge pclk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_pready", 256'(pready_v[i]), 256'(0));
            chk("rst_pslverr", 256'(pslverr_v[i]), 256'(0));
            chk("rst_prdata", 256'(prdata_v[i]), 256'(0));
            chk("rst_reg_q", regq_v[i], 256'(0));
            chk("rst_stb", 256'(stb_v[i]), 256'(0));
        end
        presetn = 1'b1;
        @(negedge pclk);

        // Directed vectors on the 1-wait-state instance.
        for (int i = 0; i < 8; i++)
            vecs.push_back('{32'(i * 4), 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0});
        vecs.push_back('{32'h20, 1'b0, 32'h0, 4'hF, ID, 1'b0, 32'h0});
        vecs.push_back('{32'h08, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 32'hDEAD_BEEF});
        vecs.push_back('{32'h08, 1'b1, 32'h1122_3344, 4'b0101, 32'h0, 1'b0, 32'hDE22_BE44});
        vecs.push_back('{32'h08, 1'b0, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0, 32'hDE22_BE44});
        vecs.push_back('{32'h20, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 32'hDE22_BE44});
        vecs.push_back('{32'h24, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'hDE22_BE44});
        vecs.push_back('{32'h06, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 32'hDE22_BE44});
        vecs.push_back('{32'h08, 1'b1, 32'hCAFE_F00D, 4'h0, 32'h0, 1'b0, 32'hDE22_BE44});
        foreach (vecs[i]) begin
            xfer(0, vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].strb, rd, er);
            chk("vec_pslverr", 256'(er), 256'(vecs[i].exp_err));
            if (!vecs[i].wr || vecs[i].exp_err) chk("vec_prdata", 256'(rd), 256'(vecs[i].exp_rd));
            chk("vec_reg2", 256'(regq_v[0][95:64]), 256'(vecs[i].exp_reg2));
            if (i % 2 == 0) idle(0);
        end
        idle(0);

        // Back-to-back read then write on the 3-wait-state instance.
        xfer(1, 32'h08, 1'b0, 32'h0, 4'h0, rd, er);
        xfer(1, 32'h0C, 1'b1, 32'h1357_9BDF, 4'hF, rd, er);
        xfer(1, 32'h0C, 1'b0, 32'h0, 4'h0, rd, er);
        chk("b2b_readback", 256'(rd), 256'(32'h1357_9BDF));
        idle(1);

        // Psel in IDLE together with penable is not a setup.
        psel_v[0] = 1'b1; penable_v[0] = 1'b1; paddr_v[0] = 32'h0; pwrite_v[0] = 1'b1;
        repeat (3) begin
            @(negedge pclk);
            chk("violation_pready", 256'(pready_v[0]), 256'(0));
        end
        idle(0);
        chk("violation_reg_q", regq_v[0], model_regs(0));

        abort_write(0, 32'h08, 1);
        abort_write(1, 32'h0C, 2);
        xfer(0, 32'h08, 1'b0, 32'h0, 4'h0, rd, er);
        idle(0);
        xfer(1, 32'h0C, 1'b0, 32'h0, 4'h0, rd, er);
        idle(1);

        // Reset asserted while the 3-wait-state instance sits in WAIT.
        paddr_v[1] = 32'h10; pwrite_v[1] = 1'b1; pwdata_v[1] = 32'hFFFF_FFFF; pstrb_v[1] = 4'hF;
        psel_v[1] = 1'b1; penable_v[1] = 1'b0;
        @(negedge pclk);
        penable_v[1] = 1'b1;
        @(negedge pclk);
        presetn = 1'b0;
        model_reset();
        #1;
        chk("midrst_reg_q", regq_v[1], 256'(0));
        chk("midrst_pready", 256'(pready_v[1]), 256'(0));
        @(negedge pclk);
        presetn = 1'b1;
        idle(1);
        repeat (4) begin
            @(negedge pclk);
            chk("postrst_pready", 256'(pready_v[1]), 256'(0));
            chk("postrst_stb", 256'(stb_v[1]), 256'(0));
        end
        xfer(1, 32'h10, 1'b0, 32'h0, 4'h0, rd, er);
        idle(1);

        // Randomized transfers on both instances against the model.
        last = 0;
        for (int i = 0; i < 300; i++) begin
            d = int'($urandom_range(0, 1));
            if (d != last) begin
                psel_v[last] = 1'b0; penable_v[last] = 1'b0;
            end
            a = 32'($urandom_range(0, 11)) * 4;
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            xfer(d, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), rd, er);
            if ($urandom_range(0, 1) == 1) idle(d);
            last = d;
        end
        idle(0);
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
